// File: rtl/mem_stage_ooo_resp.sv
// ============================================================================
// mem_stage_ooo_resp : MEM stage with variable-latency data response, response
// buffering under WB stall, load extraction and cancelled-response discard.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_stage_ooo_resp #(
  parameter int PC_W         = 32,
  parameter int DEST_W       = 5,
  parameter int CANCEL_DEPTH = 3
) (
  input  logic              clk,
  input  logic              resetn,
  // EXE -> MEM
  input  logic              es_to_ms_valid,
  output logic              ms_allowin,
  input  logic [PC_W-1:0]   es_pc,
  input  logic              es_gr_we,
  input  logic [DEST_W-1:0] es_dest,
  input  logic [31:0]       es_alu_result,
  input  logic              es_mem_req,
  input  logic              es_res_from_mem,
  input  logic [2:0]        es_load_op,
  // data bus response
  input  logic              data_sram_data_ok,
  input  logic [31:0]       data_sram_rdata,
  // control
  input  logic              flush,
  output logic              ms_cancel_full,
  // MEM -> WB
  output logic              ms_to_ws_valid,
  input  logic              ws_allowin,
  output logic [PC_W-1:0]   ms_pc,
  output logic              ms_gr_we,
  output logic [DEST_W-1:0] ms_dest,
  output logic [31:0]       ms_final_result,
  // forwarding to ID
  output logic [DEST_W-1:0] ms_fwd_dest,
  output logic [31:0]       ms_fwd_data,
  output logic              ms_fwd_stall
);

  localparam int              CNT_W   = $clog2(CANCEL_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CANCEL_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LH  = 3'b010;
  localparam logic [2:0] OP_LBU = 3'b011;
  localparam logic [2:0] OP_LHU = 3'b100;

  logic             ms_valid;
  logic [31:0]      alu_result;
  logic             mem_req;
  logic             res_from_mem;
  logic [2:0]       load_op;
  logic             resp_got;
  logic [31:0]      rdata_buf;
  logic [CNT_W-1:0] cancel_cnt;

  logic        cur_ok;
  logic        drop_resp;
  logic        ms_ready_go;
  logic        cancel_inc;
  logic        buf_resp;
  logic [31:0] raw_data;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  // Responses return in order, so while cancels are owed the oldest one is never ours.
  assign cur_ok    = data_sram_data_ok && (cancel_cnt == '0);
  assign drop_resp = data_sram_data_ok && (cancel_cnt != '0);

  assign ms_ready_go    = !mem_req || resp_got || cur_ok;
  assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go && !flush;

  assign cancel_inc = flush && ms_valid && mem_req && !resp_got && !cur_ok;
  assign buf_resp   = cur_ok && ms_valid && mem_req && !resp_got && !ms_allowin;

  assign raw_data = resp_got ? rdata_buf : data_sram_rdata;

  always_comb begin
    byte_sel = raw_data[7:0];
    case (alu_result[1:0])
      2'd0:    byte_sel = raw_data[7:0];
      2'd1:    byte_sel = raw_data[15:8];
      2'd2:    byte_sel = raw_data[23:16];
      default: byte_sel = raw_data[31:24];
    endcase
  end

  assign half_sel = alu_result[1] ? raw_data[31:16] : raw_data[15:0];

  always_comb begin
    load_data = raw_data;
    case (load_op)
      OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_data = {24'd0, byte_sel};
      OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_data = {16'd0, half_sel};
      default: load_data = raw_data;
    endcase
  end

  assign ms_final_result = res_from_mem ? load_data : alu_result;
  assign ms_fwd_data     = ms_final_result;
  assign ms_fwd_dest     = (ms_valid && ms_gr_we) ? ms_dest : '0;
  assign ms_fwd_stall    = ms_valid && ms_gr_we && res_from_mem && !ms_ready_go;
  assign ms_cancel_full  = (cancel_cnt == CNT_MAX);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid  <= 1'b0;
      resp_got  <= 1'b0;
      rdata_buf <= '0;
    end else if (flush) begin
      ms_valid <= 1'b0;
      resp_got <= 1'b0;
    end else if (ms_allowin) begin
      ms_valid <= es_to_ms_valid;
      resp_got <= 1'b0;
    end else if (buf_resp) begin
      resp_got  <= 1'b1;
      rdata_buf <= data_sram_rdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_pc        <= '0;
      ms_gr_we     <= 1'b0;
      ms_dest      <= '0;
      alu_result   <= '0;
      mem_req      <= 1'b0;
      res_from_mem <= 1'b0;
      load_op      <= '0;
    end else if (ms_allowin && es_to_ms_valid) begin
      ms_pc        <= es_pc;
      ms_gr_we     <= es_gr_we;
      ms_dest      <= es_dest;
      alu_result   <= es_alu_result;
      mem_req      <= es_mem_req;
      res_from_mem <= es_res_from_mem;
      load_op      <= es_load_op;
    end
  end

  // A new cancel and a dropped response in the same cycle cancel each other out.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cancel_cnt <= '0;
    end else begin
      case ({cancel_inc, drop_resp})
        2'b10: if (cancel_cnt != CNT_MAX) cancel_cnt <= cancel_cnt + CNT_ONE;
        2'b01: cancel_cnt <= cancel_cnt - CNT_ONE;
        default: cancel_cnt <= cancel_cnt;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_ooo_resp.sv
// Directed bench for mem_stage_ooo_resp: transaction model checked every cycle
// plus literal expectations from hand-worked cases.
`default_nettype none

module tb_mem_stage_ooo_resp;

  logic        clk = 1'b0;
  logic        resetn;
  logic        es_to_ms_valid;
  logic        ms_allowin;
  logic [31:0] es_pc;
  logic        es_gr_we;
  logic [4:0]  es_dest;
  logic [31:0] es_alu_result;
  logic        es_mem_req;
  logic        es_res_from_mem;
  logic [2:0]  es_load_op;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        flush;
  logic        ms_cancel_full;
  logic        ms_to_ws_valid;
  logic        ws_allowin;
  logic [31:0] ms_pc;
  logic        ms_gr_we;
  logic [4:0]  ms_dest;
  logic [31:0] ms_final_result;
  logic [4:0]  ms_fwd_dest;
  logic [31:0] ms_fwd_data;
  logic        ms_fwd_stall;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_stage_ooo_resp #(.PC_W(32), .DEST_W(5), .CANCEL_DEPTH(3)) dut (
    .clk(clk), .resetn(resetn),
    .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
    .es_pc(es_pc), .es_gr_we(es_gr_we), .es_dest(es_dest),
    .es_alu_result(es_alu_result), .es_mem_req(es_mem_req),
    .es_res_from_mem(es_res_from_mem), .es_load_op(es_load_op),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .flush(flush), .ms_cancel_full(ms_cancel_full),
    .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
    .ms_pc(ms_pc), .ms_gr_we(ms_gr_we), .ms_dest(ms_dest),
    .ms_final_result(ms_final_result),
    .ms_fwd_dest(ms_fwd_dest), .ms_fwd_data(ms_fwd_data), .ms_fwd_stall(ms_fwd_stall)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] addr;
    logic        mem_req;
    logic        from_mem;
    logic [2:0]  op;
    logic        have;
    logic [31:0] data;
  } inst_t;

  inst_t m;
  int    owed;   // responses still to be thrown away

  function automatic logic [31:0] extract(input logic [2:0] op, input logic [1:0] a,
                                          input logic [31:0] raw);
    int unsigned b, h;
    b = (raw >> (8 * a)) & 32'hFF;
    h = (raw >> (16 * a[1])) & 32'hFFFF;
    case (op)
      3'd1:    return (b >= 128) ? b - 256 : b;
      3'd2:    return (h >= 32768) ? h - 65536 : h;
      3'd3:    return b;
      3'd4:    return h;
      default: return raw;
    endcase
  endfunction

  function automatic logic model_ready(input inst_t i, input int ow, input logic ok);
    return !i.mem_req || i.have || (ok && ow == 0);
  endfunction

  always @(posedge clk or negedge resetn) begin
    inst_t n;
    int    ow;
    logic  fresh, adv;
    if (!resetn) begin
      m    <= '0;
      owed <= 0;
    end else begin
      n     = m;
      ow    = owed;
      fresh = data_sram_data_ok && ow == 0;
      adv   = !m.valid || (model_ready(m, ow, data_sram_data_ok) && ws_allowin);
      if (data_sram_data_ok && ow > 0) ow = ow - 1;
      else if (fresh && m.valid && m.mem_req && !m.have && !adv) begin
        n.have = 1'b1;
        n.data = data_sram_rdata;
      end
      if (flush && m.valid && m.mem_req && !m.have && !fresh) ow = (ow + 1 > 3) ? 3 : ow + 1;
      if (flush) begin
        n.valid = 1'b0;
        n.have  = 1'b0;
      end else if (adv) begin
        n.valid = es_to_ms_valid;
        n.have  = 1'b0;
      end
      if (adv && es_to_ms_valid) begin
        n.pc = es_pc; n.gr_we = es_gr_we; n.dest = es_dest; n.addr = es_alu_result;
        n.mem_req = es_mem_req; n.from_mem = es_res_from_mem; n.op = es_load_op;
      end
      m    <= n;
      owed <= ow;
    end
  end

  // compare process: inputs are stable around the falling edge
  always @(negedge clk) begin
    logic        rdy, tows;
    logic [31:0] res;
    rdy  = model_ready(m, owed, data_sram_data_ok);
    tows = m.valid && rdy && !flush;
    chk("allowin", {31'd0, ms_allowin}, {31'd0, !m.valid || (rdy && ws_allowin)});
    chk("to_ws_valid", {31'd0, ms_to_ws_valid}, {31'd0, tows});
    chk("fwd_dest", {27'd0, ms_fwd_dest}, (m.valid && m.gr_we) ? {27'd0, m.dest} : 32'd0);
    chk("fwd_stall", {31'd0, ms_fwd_stall}, {31'd0, m.valid && m.gr_we && m.from_mem && !rdy});
    chk("cancel_full", {31'd0, ms_cancel_full}, {31'd0, owed == 3});
    if (tows) begin
      res = m.from_mem ? extract(m.op, m.addr[1:0], m.have ? m.data : data_sram_rdata) : m.addr;
      chk("pc", ms_pc, m.pc);
      chk("gr_we", {31'd0, ms_gr_we}, {31'd0, m.gr_we});
      chk("dest", {27'd0, ms_dest}, {27'd0, m.dest});
      chk("result", ms_final_result, res);
      chk("fwd_data", ms_fwd_data, res);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic enter(input logic [31:0] pc, input logic we, input logic [4:0] d,
                       input logic [31:0] alu, input logic mreq, input logic fm,
                       input logic [2:0] op);
    es_pc = pc; es_gr_we = we; es_dest = d; es_alu_result = alu;
    es_mem_req = mreq; es_res_from_mem = fm; es_load_op = op;
    es_to_ms_valid = 1'b1;
    tick();
    es_to_ms_valid = 1'b0;
  endtask

  task automatic resp_begin(input logic [31:0] d);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = d;
    #1;
  endtask

  // hold pulses across one rising edge, then drop them before the compare edge
  task automatic pulse_end();
    @(posedge clk);
    #1;
    data_sram_data_ok = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; es_to_ms_valid = 1'b0; es_pc = '0; es_gr_we = 1'b0; es_dest = '0;
    es_alu_result = '0; es_mem_req = 1'b0; es_res_from_mem = 1'b0; es_load_op = '0;
    data_sram_data_ok = 1'b0; data_sram_rdata = '0; flush = 1'b0; ws_allowin = 1'b1;
    tick(); tick();
    chk("rst_allowin", {31'd0, ms_allowin}, 32'd1);
    chk("rst_to_ws", {31'd0, ms_to_ws_valid}, 32'd0);
    chk("rst_result", ms_final_result, 32'd0);
    chk("rst_full", {31'd0, ms_cancel_full}, 32'd0);
    chk("rst_fwd_dest", {27'd0, ms_fwd_dest}, 32'd0);
    resetn = 1'b1;
    tick();

    // ADD: one cycle in MEM
    enter(32'h100, 1, 5'd3, 32'h1234, 0, 0, 3'd0);
    chk("add_valid", {31'd0, ms_to_ws_valid}, 32'd1);
    chk("add_result", ms_final_result, 32'h1234);
    tick();
    chk("add_gone", {31'd0, ms_to_ws_valid}, 32'd0);

    // LB lane 3, response after three stall cycles
    enter(32'h200, 1, 5'd5, 32'h1003, 1, 1, 3'd1);
    for (int i = 0; i < 3; i++) begin
      chk("lb_stall", {31'd0, ms_fwd_stall}, 32'd1);
      if (i < 2) tick();
    end
    tick();
    resp_begin(32'h80FF_FF12);
    chk("lb_valid", {31'd0, ms_to_ws_valid}, 32'd1);
    chk("lb_result", ms_final_result, 32'hFFFF_FF80);
    pulse_end();
    chk("lb_gone", {31'd0, ms_to_ws_valid}, 32'd0);

    // LBU, response in the first cycle
    enter(32'h204, 1, 5'd6, 32'h1007, 1, 1, 3'd3);
    resp_begin(32'h80FF_FF12);
    chk("lbu_result", ms_final_result, 32'h0000_0080);
    pulse_end();

    // LH sign-extended upper half
    enter(32'h208, 1, 5'd7, 32'h5002, 1, 1, 3'd2);
    resp_begin(32'h8001_0000);
    chk("lh_result", ms_final_result, 32'hFFFF_8001);
    pulse_end();

    // LHU with WB stalled: response is buffered
    enter(32'h20C, 1, 5'd9, 32'h2002, 1, 1, 3'd4);
    ws_allowin = 1'b0;
    resp_begin(32'hBEEF_0000);
    chk("lhu_allowin", {31'd0, ms_allowin}, 32'd0);
    pulse_end();
    data_sram_rdata = 32'h0;
    #1;
    chk("lhu_buf_result", ms_final_result, 32'h0000_BEEF);
    tick();
    chk("lhu_buf_valid", {31'd0, ms_to_ws_valid}, 32'd1);
    chk("lhu_buf_result2", ms_final_result, 32'h0000_BEEF);
    ws_allowin = 1'b1;
    tick();
    chk("lhu_gone", {31'd0, ms_to_ws_valid}, 32'd0);

    // store: no register write, waits for its response
    enter(32'h210, 0, 5'd0, 32'h6000, 1, 0, 3'd0);
    chk("st_wait", {31'd0, ms_to_ws_valid}, 32'd0);
    chk("st_nostall", {31'd0, ms_fwd_stall}, 32'd0);
    resp_begin(32'h1111_1111);
    chk("st_result", ms_final_result, 32'h6000);
    pulse_end();

    // flush a pending load, then drop its late response
    enter(32'h300, 1, 5'd7, 32'h3000, 1, 1, 3'd0);
    flush = 1'b1;
    #1;
    chk("fl_to_ws", {31'd0, ms_to_ws_valid}, 32'd0);
    pulse_end();
    enter(32'h304, 1, 5'd8, 32'h3004, 1, 1, 3'd0);
    resp_begin(32'h0000_DEAD);
    chk("fl_dropped", {31'd0, ms_to_ws_valid}, 32'd0);
    chk("fl_stall", {31'd0, ms_fwd_stall}, 32'd1);
    pulse_end();
    resp_begin(32'h0000_5555);
    chk("fl_valid", {31'd0, ms_to_ws_valid}, 32'd1);
    chk("fl_result", ms_final_result, 32'h0000_5555);
    pulse_end();

    // three cancels fill the counter
    for (int i = 0; i < 3; i++) begin
      enter(32'h400 + 32'(4 * i), 1, 5'd10, 32'h4000, 1, 1, 3'd0);
      flush = 1'b1;
      pulse_end();
    end
    chk("full_set", {31'd0, ms_cancel_full}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      resp_begin(32'hAAAA_0000 + 32'(i));
      pulse_end();
      chk("full_clear", {31'd0, ms_cancel_full}, 32'd0);
    end

    // flush together with a live response consumes it
    enter(32'h500, 1, 5'd11, 32'h5000, 1, 1, 3'd0);
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h7777; flush = 1'b1;
    #1;
    chk("flok_to_ws", {31'd0, ms_to_ws_valid}, 32'd0);
    pulse_end();
    enter(32'h504, 1, 5'd12, 32'h5004, 1, 1, 3'd0);
    resp_begin(32'h9999);
    chk("flok_next", ms_final_result, 32'h9999);
    chk("flok_next_valid", {31'd0, ms_to_ws_valid}, 32'd1);
    pulse_end();

    // asynchronous reset during a wait
    enter(32'h600, 1, 5'd13, 32'h6000, 1, 1, 3'd0);
    chk("ar_stall", {31'd0, ms_fwd_stall}, 32'd1);
    #1;
    resetn = 1'b0;
    #1;
    chk("ar_stall_clr", {31'd0, ms_fwd_stall}, 32'd0);
    chk("ar_allowin", {31'd0, ms_allowin}, 32'd1);
    chk("ar_fwd_dest", {27'd0, ms_fwd_dest}, 32'd0);
    tick();
    resetn = 1'b1;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_stage_ooo_resp.md
# mem_stage_ooo_resp

Memory-access pipeline stage for the 5-stage in-order core, successor to the fixed single-cycle MEM stage. It holds one instruction between EXE and WB and waits a variable number of cycles for the data-SRAM-like bus response (`data_ok`). It buffers a response that arrives while WB is stalled and performs byte/half-word load extraction with sign/zero extension. On pipeline flush it discards responses that belong to cancelled requests, using a parametrised cancel counter.

## Interface
- `PC_W`, 32, width of instruction PC carried through the stage
- `DEST_W`, 5, register-file destination index width
- `CANCEL_DEPTH`, 3, max number of cancelled outstanding responses tracked; counter width is clog2(CANCEL_DEPTH+1)

- `clk` in 1 — stage clock, all state on rising edge
- `resetn` in 1 — asynchronous, active-low reset
- `es_to_ms_valid` in 1 — EXE holds a valid instruction for MEM
- `ms_allowin` out 1 — MEM accepts from EXE this cycle
- `es_pc` in PC_W — PC of incoming instruction
- `es_gr_we` in 1 — incoming instruction writes the register file
- `es_dest` in DEST_W — destination register
- `es_alu_result` in 32 — ALU result; for memory ops, the effective address
- `es_mem_req` in 1 — incoming instruction issued a data request accepted by the bus (load or store)
- `es_res_from_mem` in 1 — result comes from memory (load)
- `es_load_op` in 3 — 000 LW, 001 LB, 010 LH, 011 LBU, 100 LHU; other codes are treated as LW
- `data_sram_data_ok` in 1 — one response returned, in request order
- `data_sram_rdata` in 32 — read data, valid with `data_ok`
- `flush` in 1 — cancel the instruction held in MEM (exception/ertn)
- `ms_cancel_full` out 1 — cancel counter at CANCEL_DEPTH; EXE must not issue new requests
- `ms_to_ws_valid` out 1 — valid result for WB
- `ws_allowin` in 1 — WB accepts
- `ms_pc` out PC_W, `ms_gr_we` out 1, `ms_dest` out DEST_W, `ms_final_result` out 32 — payload to WB
- `ms_fwd_dest` out DEST_W — forwarding destination; 0 when not writing
- `ms_fwd_data` out 32 — equals `ms_final_result`
- `ms_fwd_stall` out 1 — MEM holds a load whose data has not yet returned; ID must stall on a match

## Operation
- The stage holds registers `ms_valid`, the payload fields, `resp_got`, `rdata_buf[31:0]`, and `cancel_cnt`.
- `cur_ok` = `data_ok` && `cancel_cnt==0`.
- `ms_ready_go` = !`es_mem_req`(latched) || `resp_got` || `cur_ok`.
- `ms_allowin` = !`ms_valid` || (`ms_ready_go` && `ws_allowin`).
- `ms_to_ws_valid` = `ms_valid` && `ms_ready_go` && !`flush`.
- Load from EXE when `ms_allowin`:
  - `ms_valid` <= `es_to_ms_valid` && !`flush`.
  - Payload is captured only when `es_to_ms_valid`.
  - `resp_got` <= 0.
- Response handling:
  - If `data_ok` and `cancel_cnt>0`: decrement `cancel_cnt` and drop the data. This takes priority because responses are in order, so the oldest response belongs to a cancelled request.
  - Else if `data_ok`, `ms_valid`, latched `mem_req`, !`resp_got`, and the stage does not advance this cycle: set `resp_got`=1 and `rdata_buf`<=`rdata`.
- Data select: raw = `resp_got` ? `rdata_buf` : `data_sram_rdata`.
- Byte lane = `alu_result[1:0]`; half lane = `alu_result[1]`.
- LB/LBU: byte at lane, sign- or zero-extended to 32. LH/LHU: half at lane, sign- or zero-extended. LW: raw.
- `ms_final_result` = `res_from_mem` ? extended data : `alu_result`.
- Flush, while `ms_valid` && `mem_req` && !`resp_got` && !`cur_ok`:
  - `cancel_cnt`++ (saturates at CANCEL_DEPTH).
  - `ms_valid`<=0 regardless.
- Flush coinciding with `cur_ok` consumes that response; `cancel_cnt` is unchanged.
- `ms_cancel_full` = (`cancel_cnt`==CANCEL_DEPTH).
- Forwarding:
  - `ms_fwd_dest` = (`ms_valid` && `gr_we`) ? `dest` : 0.
  - `ms_fwd_stall` = `ms_valid` && `gr_we` && `res_from_mem` && !`ms_ready_go`.

## Timing
- Reset (async assert, released synchronously to `clk`): `ms_valid`=0, `resp_got`=0, `cancel_cnt`=0, `rdata_buf`=0, payload=0.
- All outputs are therefore 0 after reset except `ms_allowin`=1.
- Non-memory instruction: one cycle in MEM, same as the old stage.
- Load/store: leaves MEM in the cycle `cur_ok` is seen, if `ws_allowin`=1. Result bypasses combinationally from `rdata`, so there is no added cycle.
- Response arriving while WB is stalled: buffered. The instruction leaves on the first later cycle with `ws_allowin`=1, and `data_ok` is not needed again.
- A response can arrive in the first cycle `ms_valid`=1. A response never precedes the instruction's entry to MEM.
- `data_ok` with `ms_valid`=0 and `cancel_cnt`=0 is a protocol error and is ignored.

## Test plan
- ADD result 0x1234 with `ws_allowin`=1 -> `ms_to_ws_valid`=1 the cycle after entry; `ms_final_result`=0x1234.
- LB, address 0x...3, `data_ok` 3 cycles later with `rdata`=0x80FF_FF12 -> `ms_fwd_stall`=1 for 3 cycles, then result 0xFFFF_FF80. The same case with LBU gives 0x0000_0080.
- LHU, address 0x...2, `data_ok` arrives while `ws_allowin`=0 for 2 cycles with `rdata`=0xBEEF_0000 -> result 0x0000_BEEF after WB reopens, with no second `data_ok` required.
- Load pending, `flush` pulsed -> `cancel_cnt`=1. Next load enters; first `data_ok` (0xDEAD) is dropped; second (0x5555) becomes its result.
- CANCEL_DEPTH=3: three consecutive flushed pending loads -> `ms_cancel_full`=1. Three `data_ok` return `cancel_cnt` to 0 and `ms_cancel_full`=0.
- Flush in the same cycle as `cur_ok` -> `cancel_cnt` stays 0 and `ms_to_ws_valid`=0. Async `resetn` low mid-wait -> `ms_valid`=0 immediately.
